scr1_mem_arbiter: RTL and testbench
===================================

Name: scr1_mem_arbiter

Overview:
- N-port arbiter that merges the SCR1-style memory interfaces of `N_CORES` scr1 cores onto one shared memory port. It supports both IMEM and DMEM traffic.
- Successor to the single-core, switch-driven memory hookup.
- Adds round-robin fairness, request buffering, and a response timeout with error reporting.
- Sits between the core array and the shared on-chip or SDRAM memory controller in the multicore top.

Parameters:
- `N_CORES`, 4: number of requesting cores (2..16).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 255: max cycles waiting for a memory response before an error is returned. 0 disables the timeout.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `core_req_i`  in  N_CORES  per-core request, held until acked.
- `core_cmd_i`  in  N_CORES  per-core command: 0 = read, 1 = write.
- `core_width_i`  in  2*N_CORES  per-core access width: 0 = byte, 1 = half, 2 = word.
- `core_addr_i`  in  AW*N_CORES  per-core address.
- `core_wdata_i`  in  DW*N_CORES  per-core write data.
- `core_req_ack_o`  out  N_CORES  one-hot request accept.
- `core_rdata_o`  out  DW  read data, broadcast to all cores; valid only with a non-zero `core_resp_o` slice.
- `core_resp_o`  out  2*N_CORES  per-core response: 0 = not ready, 1 = ok, 2 = error.
- `mem_req_o`  out  1  shared-port request.
- `mem_cmd_o`  out  1  shared-port command.
- `mem_width_o`  out  2  shared-port access width.
- `mem_addr_o`  out  AW  shared-port address.
- `mem_wdata_o`  out  DW  shared-port write data.
- `mem_req_ack_i`  in  1  memory accepted the request.
- `mem_rdata_i`  in  DW  memory read data.
- `mem_resp_i`  in  2  memory response, same encoding as `core_resp_o`.

Behaviour:
- **Reset:**
  - State goes to IDLE; round-robin pointer `ptr` = 0; grant register `g` = 0; timeout counter = 0.
  - All outputs are 0: req_ack, resp, rdata, all `mem_*` outputs.
  - Reset asserted mid-transaction abandons it immediately. There is no memory of the pending transfer.
- **FSM states:** IDLE, ISSUE, WAIT, DRAIN.
- **IDLE:**
  - If any `core_req_i` is set, select the first requester at or after `ptr`, wrapping modulo `N_CORES`.
  - Assert `core_req_ack_o[sel]` combinationally in the same cycle. No other ack bit is ever set.
  - Latch `cmd`, `width`, `addr` and `wdata` of `sel` into the buffer; `g` <= `sel`; go to ISSUE.
  - With no requests, stay in IDLE.
- **ISSUE:**
  - `mem_req_o` = 1; `mem_*` outputs are driven from the buffer.
  - On `mem_req_ack_i` = 1: go to WAIT, clear the counter.
  - `mem_resp_i` is ignored in ISSUE.
  - The timeout does not apply in ISSUE; it stalls indefinitely.
- **WAIT:**
  - `mem_req_o` = 0; the counter increments each cycle.
  - If `mem_resp_i` != 0:
    - `core_resp_o[g]` = `mem_resp_i` for exactly one cycle (combinational pass-through).
    - `core_rdata_o` = `mem_rdata_i`.
    - `ptr` <= (`g`+1) mod `N_CORES`; go to IDLE.
  - Else if `TIMEOUT` != 0 and counter == `TIMEOUT`-1:
    - `core_resp_o[g]` = 2 (error) for one cycle; `core_rdata_o` = 0.
    - `ptr` <= `g`+1; go to DRAIN.
  - A response arriving in the same cycle as the timeout wins: the ok/error from memory is forwarded and the FSM goes to IDLE, not DRAIN.
- **DRAIN:**
  - Wait for the late `mem_resp_i` != 0, discard it, go to IDLE.
  - No new request is issued while draining, so a late response cannot be misrouted.
- **Response isolation:** `core_resp_o` slices for non-granted cores are always 0.
- **Pointer advance:** `ptr` advances only on completion (response or timeout). A sole requester therefore gets back-to-back service.
- **Latency:** ack to the core is 0 cycles in IDLE. Minimum turnaround is ack(IDLE) → ISSUE → WAIT with response → IDLE, i.e. 3 cycles per transfer. The next grant is possible in the cycle after the response.
- **Late requests:** a core asserting `req` while the arbiter is busy simply waits. Its request must stay stable until acked.
- **Widths:**
  - `width` and `wdata` pass through unmodified. Byte-lane alignment is the memory's job.
  - Counter width is `$clog2(TIMEOUT+1)`, saturating at `TIMEOUT`-1.
  - `core_*` vectors are flat-packed, core k occupying `[k*W +: W]`.

Test Plan:
- **Single read:** core 1 reads addr 0x100; memory acks in ISSUE's first cycle and returns resp=1, rdata=0xDEADBEEF two cycles later → `core_req_ack_o`=4'b0010 in one cycle; `core_resp_o[1]`=1 and `core_rdata_o`=0xDEADBEEF for exactly one cycle; all other resp slices 0.
- **Round-robin:** all 4 cores hold reads from reset, memory always responds immediately → grant order 0,1,2,3,0; each ack one-hot; no core is served twice before the others.
- **Write pass-through:** core 2 writes width=1, addr 0x2002, wdata 0x0000BEEF; memory holds `mem_req_ack_i`=0 for 5 cycles → `mem_req_o` is held with stable `mem_cmd_o`=1, `mem_width_o`=1, addr and data; then one ok response goes to core 2.
- **Timeout and drain:** `TIMEOUT`=8; memory acks but responds only after 12 cycles → `core_resp_o[g]`=2 on the 8th WAIT cycle. A core-3 request during DRAIN is not acked until the late response is consumed, then it is granted.
- **Response/timeout collision:** `TIMEOUT`=8; memory response lands on the 8th WAIT cycle → ok forwarded; FSM goes to IDLE, not DRAIN.
- **Async reset:** assert `rst_n`=0 mid-WAIT between clock edges → all outputs go to 0 immediately. After release, the first grant goes to core 0 when all cores request.

Source files
------------

// File: rtl/scr1_mem_arbiter.sv
// scr1_mem_arbiter: round-robin merge of N_CORES SCR1 memory ports onto one shared port,
// with a buffered request, a response timeout and a drain state for late responses.
module scr1_mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CORES-1:0]   core_req_i,
  input  logic [N_CORES-1:0]   core_cmd_i,
  input  logic [2*N_CORES-1:0] core_width_i,
  input  logic [AW*N_CORES-1:0] core_addr_i,
  input  logic [DW*N_CORES-1:0] core_wdata_i,
  output logic [N_CORES-1:0]   core_req_ack_o,
  output logic [DW-1:0]        core_rdata_o,
  output logic [2*N_CORES-1:0] core_resp_o,
  output logic                 mem_req_o,
  output logic                 mem_cmd_o,
  output logic [1:0]           mem_width_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic                 mem_req_ack_i,
  input  logic [DW-1:0]        mem_rdata_i,
  input  logic [1:0]           mem_resp_i
);
  localparam int PW = N_CORES > 1 ? $clog2(N_CORES) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, g_q, g_d, sel, sel_lo, sel_hi, nxt;
  logic found, hi_found, tmo;
  logic cmd_q, cmd_d;
  logic [1:0] width_q, width_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign nxt = (g_q == PW'(N_CORES - 1)) ? '0 : g_q + 1'b1;
  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  // Lowest requester at or above ptr wins, else lowest overall (wrap-around).
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    found    = 1'b0;
    hi_found = 1'b0;
    for (int j = N_CORES - 1; j >= 0; j--) begin
      if (core_req_i[j]) begin
        found  = 1'b1;
        sel_lo = PW'(j);
      end
      if (core_req_i[j] && PW'(j) >= ptr_q) begin
        hi_found = 1'b1;
        sel_hi   = PW'(j);
      end
    end
    sel = hi_found ? sel_hi : sel_lo;
  end
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    g_d            = g_q;
    cmd_d          = cmd_q;
    width_d        = width_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    core_req_ack_o = '0;
    core_resp_o    = '0;
    core_rdata_o   = '0;
    mem_req_o      = 1'b0;
    mem_cmd_o      = 1'b0;
    mem_width_o    = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    case (state_q)
      IDLE: if (found) begin
        core_req_ack_o[sel] = rst_n;
        cmd_d   = core_cmd_i[sel];
        width_d = core_width_i[int'(sel)*2 +: 2];
        addr_d  = core_addr_i[int'(sel)*AW +: AW];
        wdata_d = core_wdata_i[int'(sel)*DW +: DW];
        g_d     = sel;
        state_d = ISSUE;
      end
      ISSUE: begin
        mem_req_o   = 1'b1;
        mem_cmd_o   = cmd_q;
        mem_width_o = width_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_req_ack_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = tmo ? cnt_q : cnt_q + 1'b1;
        if (mem_resp_i != 2'd0) begin
          core_resp_o[int'(g_q)*2 +: 2] = mem_resp_i;
          core_rdata_o = mem_rdata_i;
          ptr_d   = nxt;
          state_d = IDLE;
        end else if (tmo) begin
          core_resp_o[int'(g_q)*2 +: 2] = 2'd2;
          ptr_d   = nxt;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = (mem_resp_i != 2'd0) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cmd_q   <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// tb_scr1_mem_arbiter: directed checks of arbitration, pass-through, timeout/drain and reset.
module tb_scr1_mem_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] core_req, core_cmd, ack;
  logic [2*N-1:0] core_width, resp;
  logic [AW*N-1:0] core_addr;
  logic [DW*N-1:0] core_wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_req, mem_cmd, mem_req_ack;
  logic [1:0] mem_width, mem_resp;
  logic [AW-1:0] mem_addr;
  int tests = 0;
  int fails = 0;
  scr1_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_cmd_i(core_cmd), .core_width_i(core_width),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_req_ack_o(ack), .core_rdata_o(rdata), .core_resp_o(resp),
    .mem_req_o(mem_req), .mem_cmd_o(mem_cmd), .mem_width_o(mem_width),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_req_ack_i(mem_req_ack), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );
  always #5 clk = ~clk;
  task automatic reset_dut();
    rst_n = 1'b0;
    core_req = '0; core_cmd = '0; core_width = '0; core_addr = '0; core_wdata = '0;
    mem_req_ack = 1'b0; mem_rdata = '0; mem_resp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic set_req(input int k, input logic c, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
    core_req[k] = 1'b1;
    core_cmd[k] = c;
    core_width[k*2 +: 2] = w;
    core_addr[k*AW +: AW] = a;
    core_wdata[k*DW +: DW] = d;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    core_req = 4'hF; mem_resp = 2'd1; mem_rdata = 32'h5; mem_req_ack = 1'b1;
    #3;
    tests++;
    if ({ack, resp, rdata, mem_req, mem_cmd, mem_width, mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b resp=%b rdata=%h mem_req=%b mem_addr=%h", ack, resp, rdata, mem_req, mem_addr);
    end
    reset_dut();
  endtask
  task automatic test_single_read();
    reset_dut();
    set_req(1, 1'b0, 2'd2, 32'h100, 32'h0);
    #1; tests++;
    if (ack !== 4'b0010) begin fails++; $display("FAIL read_ack: got %b want 0010", ack); end
    @(negedge clk); core_req = '0; mem_req_ack = 1'b1;
    #1; tests++;
    if ({ack, mem_req, mem_cmd, mem_width, mem_addr} !== {4'b0, 1'b1, 1'b0, 2'd2, 32'h100}) begin
      fails++; $display("FAIL read_issue: ack=%b req=%b cmd=%b w=%0d addr=%h", ack, mem_req, mem_cmd, mem_width, mem_addr);
    end
    @(negedge clk); mem_req_ack = 1'b0;
    #1; tests++;
    if ({resp, mem_req} !== 9'b0) begin fails++; $display("FAIL read_wait1: resp=%b mem_req=%b want 0", resp, mem_req); end
    @(negedge clk); mem_resp = 2'd1; mem_rdata = 32'hDEADBEEF;
    #1; tests++;
    if ({resp, rdata} !== {8'h04, 32'hDEADBEEF}) begin fails++; $display("FAIL read_resp: resp=%b rdata=%h want 00000100 deadbeef", resp, rdata); end
    @(negedge clk); mem_resp = 2'd0;
    #1; tests++;
    if ({resp, rdata} !== '0) begin fails++; $display("FAIL read_resp_once: resp=%b rdata=%h want 0", resp, rdata); end
  endtask
  task automatic test_round_robin();
    int n = 0;
    reset_dut();
    mem_req_ack = 1'b1; mem_resp = 2'd1; core_req = 4'hF;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if (ack !== 4'b0) begin
        tests++;
        if (ack !== (4'b1 << (n % 4))) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", n, ack, 4'b1 << (n % 4)); end
        n++;
      end
      if (resp !== 8'b0) begin
        tests++;
        if (resp !== (8'b1 << (2 * ((n - 1) % 4)))) begin fails++; $display("FAIL rr_resp%0d: got %b", n - 1, resp); end
      end
      @(negedge clk);
    end
    tests++;
    if (n != 5) begin fails++; $display("FAIL rr_count: got %0d grants want 5", n); end
    core_req = '0; mem_resp = 2'd0; mem_req_ack = 1'b0;
  endtask
  task automatic test_write();
    reset_dut();
    set_req(2, 1'b1, 2'd1, 32'h2002, 32'h0000BEEF);
    #1; tests++;
    if (ack !== 4'b0100) begin fails++; $display("FAIL wr_ack: got %b want 0100", ack); end
    @(negedge clk); core_req = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) mem_req_ack = 1'b1;
      #1; tests++;
      if ({mem_req, mem_cmd, mem_width, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'd1, 32'h2002, 32'h0000BEEF}) begin
        fails++; $display("FAIL wr_hold%0d: req=%b cmd=%b w=%0d addr=%h data=%h", c, mem_req, mem_cmd, mem_width, mem_addr, mem_wdata);
      end
      @(negedge clk);
    end
    mem_req_ack = 1'b0; mem_resp = 2'd1;
    #1; tests++;
    if (resp !== 8'h10) begin fails++; $display("FAIL wr_resp: got %b want 00010000", resp); end
    @(negedge clk); mem_resp = 2'd0;
    #1; tests++;
    if ({mem_req, resp} !== 9'b0) begin fails++; $display("FAIL wr_done: mem_req=%b resp=%b want 0", mem_req, resp); end
  endtask
  task automatic test_timeout_drain();
    reset_dut();
    set_req(0, 1'b0, 2'd2, 32'h40, 32'h0);
    #1;
    @(negedge clk); core_req = '0; mem_req_ack = 1'b1;
    @(negedge clk); mem_req_ack = 1'b0; mem_rdata = 32'hABCD;
    for (int w = 1; w <= 7; w++) begin
      #1; tests++;
      if (resp !== 8'b0) begin fails++; $display("FAIL to_wait%0d: resp=%b want 0", w, resp); end
      @(negedge clk);
    end
    #1; tests++;
    if ({resp, rdata} !== {8'h02, 32'h0}) begin fails++; $display("FAIL to_error: resp=%b rdata=%h want 00000010 0", resp, rdata); end
    @(negedge clk); set_req(3, 1'b0, 2'd2, 32'h300, 32'h0);
    for (int w = 9; w <= 12; w++) begin
      if (w == 12) mem_resp = 2'd1;
      #1; tests++;
      if ({ack, resp} !== 12'b0) begin fails++; $display("FAIL drain%0d: ack=%b resp=%b want 0", w, ack, resp); end
      @(negedge clk);
    end
    mem_resp = 2'd0;
    #1; tests++;
    if (ack !== 4'b1000) begin fails++; $display("FAIL drain_grant: got %b want 1000", ack); end
    core_req = '0;
  endtask
  task automatic test_collision();
    reset_dut();
    set_req(1, 1'b0, 2'd2, 32'h80, 32'h0);
    #1;
    @(negedge clk); core_req = '0; mem_req_ack = 1'b1;
    @(negedge clk); mem_req_ack = 1'b0;
    repeat (7) @(negedge clk);
    mem_resp = 2'd1; mem_rdata = 32'h1234;
    #1; tests++;
    if ({resp, rdata} !== {8'h04, 32'h1234}) begin fails++; $display("FAIL coll_resp: resp=%b rdata=%h want 00000100 1234", resp, rdata); end
    @(negedge clk); mem_resp = 2'd0; set_req(2, 1'b0, 2'd2, 32'h90, 32'h0);
    #1; tests++;
    if (ack !== 4'b0100) begin fails++; $display("FAIL coll_idle: ack=%b want 0100", ack); end
    core_req = '0;
  endtask
  task automatic test_async_reset();
    reset_dut();
    set_req(1, 1'b0, 2'd2, 32'h10, 32'h0);
    #1;
    @(negedge clk); core_req = '0; mem_req_ack = 1'b1;
    @(negedge clk); mem_req_ack = 1'b0; mem_resp = 2'd1;
    @(negedge clk); mem_resp = 2'd0; set_req(2, 1'b0, 2'd2, 32'h20, 32'h0);
    #1; tests++;
    if (ack !== 4'b0100) begin fails++; $display("FAIL ar_pre_grant: got %b want 0100", ack); end
    @(negedge clk); core_req = '0; mem_req_ack = 1'b1;
    @(negedge clk); mem_req_ack = 1'b0; mem_resp = 2'd1; mem_rdata = 32'hFFFF; core_req = 4'hF;
    #1; tests++;
    if (resp !== 8'h10) begin fails++; $display("FAIL ar_pre_resp: got %b want 00010000", resp); end
    #2 rst_n = 1'b0;
    #1; tests++;
    if ({ack, resp, rdata, mem_req, mem_addr} !== '0) begin
      fails++; $display("FAIL ar_outputs: ack=%b resp=%b rdata=%h mem_req=%b", ack, resp, rdata, mem_req);
    end
    @(negedge clk); rst_n = 1'b1; mem_resp = 2'd0;
    #1; tests++;
    if (ack !== 4'b0001) begin fails++; $display("FAIL ar_first_grant: got %b want 0001", ack); end
    core_req = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout_drain();
    test_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
